// File: rtl/model_matrix_pkg.sv
// Shared types and constants for the matrix stream source.
// Contents:
//   state_t                  - stream FSM state encoding
//   ZERO/ONE_CONTROL         - index-width constants (cast to CONTROL_SIZE at use)
//   ZERO/ONE_DATA            - data-width constants (cast to DATA_SIZE at use)
package model_matrix_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        ISSUE_J = 3'd2,
        WAIT    = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [63:0] ZERO_CONTROL = 64'd0;
    localparam logic [63:0] ONE_CONTROL  = 64'd1;
    localparam logic [63:0] ZERO_DATA    = 64'd0;
    localparam logic [63:0] ONE_DATA     = 64'd1;

endpackage

// File: rtl/model_matrix_source_buffer.sv
// MAX_I x MAX_J element store for the matrix stream source.
// Ports:
//   clk_i      - clock
//   wr_en_i    - write strobe (caller gates it to IDLE)
//   wr_i_i     - write row; rows >= MAX_I are dropped
//   wr_j_i     - write column; columns >= MAX_J are dropped
//   wr_data_i  - write value
//   rd_i_i     - read row
//   rd_j_i     - read column
//   rd_data_o  - combinational read value (0 when out of range)
// Contents are deliberately not reset.
module model_matrix_source_buffer #(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64,
    parameter int unsigned MAX_I        = 4,
    parameter int unsigned MAX_J        = 4
) (
    input  logic                    clk_i,
    input  logic                    wr_en_i,
    input  logic [CONTROL_SIZE-1:0] wr_i_i,
    input  logic [CONTROL_SIZE-1:0] wr_j_i,
    input  logic [DATA_SIZE-1:0]    wr_data_i,
    input  logic [CONTROL_SIZE-1:0] rd_i_i,
    input  logic [CONTROL_SIZE-1:0] rd_j_i,
    output logic [DATA_SIZE-1:0]    rd_data_o
);

    logic [DATA_SIZE-1:0] mem_q [MAX_I][MAX_J];

    // Full-width index compares so out-of-range indices can never alias a cell.
    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < MAX_I; i++) begin
            for (int unsigned j = 0; j < MAX_J; j++) begin
                if (wr_en_i && (wr_i_i == CONTROL_SIZE'(i)) && (wr_j_i == CONTROL_SIZE'(j))) begin
                    mem_q[i][j] <= wr_data_i;
                end
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        for (int unsigned i = 0; i < MAX_I; i++) begin
            for (int unsigned j = 0; j < MAX_J; j++) begin
                if ((rd_i_i == CONTROL_SIZE'(i)) && (rd_j_i == CONTROL_SIZE'(j))) begin
                    rd_data_o = mem_q[i][j];
                end
            end
        end
    end

endmodule

// File: rtl/model_matrix_stream_source.sv
// Streams a buffered matrix row by row to a handshaking consumer.
// Optional feature macro: MODEL_MATRIX_STREAM_SOURCE_SIZE_CHECK_EN
//   (rejects zero or oversized START sizes with an ERROR+READY pulse).
// Ports:
//   CLK, RST           - clock, asynchronous active-high reset
//   START              - begin streaming (honoured in IDLE only)
//   READY              - one-cycle done pulse
//   ERROR              - one-cycle size-fault pulse (constant 0 without the macro)
//   LOAD_ENABLE/I/J/DATA - buffer write port (honoured in IDLE only)
//   SIZE_I_IN/SIZE_J_IN  - matrix extent to stream, latched on START
//   DATA_OUT_I_ENABLE  - strobe on the first element of a row
//   DATA_OUT_J_ENABLE  - strobe on every element
//   DATA_OUT           - element value, holds last value between strobes
//   NEXT_I/J_ENABLE    - consumer requests next row / element
//   CONSUMER_READY     - consumer finished the whole matrix
module model_matrix_stream_source
    import model_matrix_pkg::*;
#(
    parameter int unsigned DATA_SIZE    = 64,
    parameter int unsigned CONTROL_SIZE = 64,
    parameter int unsigned MAX_I        = 4,
    parameter int unsigned MAX_J        = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    output logic                    ERROR,
    input  logic                    LOAD_ENABLE,
    input  logic [CONTROL_SIZE-1:0] LOAD_I,
    input  logic [CONTROL_SIZE-1:0] LOAD_J,
    input  logic [DATA_SIZE-1:0]    LOAD_DATA,
    input  logic [DATA_SIZE-1:0]    SIZE_I_IN,
    input  logic [DATA_SIZE-1:0]    SIZE_J_IN,
    output logic                    DATA_OUT_I_ENABLE,
    output logic                    DATA_OUT_J_ENABLE,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    input  logic                    NEXT_I_ENABLE,
    input  logic                    NEXT_J_ENABLE,
    input  logic                    CONSUMER_READY
);

    localparam logic [CONTROL_SIZE-1:0] C_ZERO = CONTROL_SIZE'(ZERO_CONTROL);
    localparam logic [CONTROL_SIZE-1:0] C_ONE  = CONTROL_SIZE'(ONE_CONTROL);
    localparam logic [DATA_SIZE-1:0]    D_ZERO = DATA_SIZE'(ZERO_DATA);

    state_t                  state_q, state_d;
    logic [CONTROL_SIZE-1:0] i_q, i_d, j_q, j_d;
    logic [DATA_SIZE-1:0]    size_i_q, size_i_d, size_j_q, size_j_d;
    logic [DATA_SIZE-1:0]    data_q, data_d;
    logic                    error_q, error_d;
    logic [DATA_SIZE-1:0]    rd_data;
    logic [CONTROL_SIZE-1:0] last_i, last_j;
    logic                    size_bad;
    logic                    wr_en, strobe_i, strobe_j, done;

`ifdef MODEL_MATRIX_STREAM_SOURCE_SIZE_CHECK_EN
    assign size_bad = (SIZE_I_IN == D_ZERO) || (SIZE_J_IN == D_ZERO) ||
                      (SIZE_I_IN > DATA_SIZE'(MAX_I)) || (SIZE_J_IN > DATA_SIZE'(MAX_J));
`else
    assign size_bad = 1'b0;
`endif

    // Last valid index at control width; unsigned compares against these.
    assign last_i = CONTROL_SIZE'(size_i_q) - C_ONE;
    assign last_j = CONTROL_SIZE'(size_j_q) - C_ONE;

    model_matrix_source_buffer #(
        .DATA_SIZE    (DATA_SIZE),
        .CONTROL_SIZE (CONTROL_SIZE),
        .MAX_I        (MAX_I),
        .MAX_J        (MAX_J)
    ) u_buffer (
        .clk_i     (CLK),
        .wr_en_i   (wr_en),
        .wr_i_i    (LOAD_I),
        .wr_j_i    (LOAD_J),
        .wr_data_i (LOAD_DATA),
        .rd_i_i    (i_q),
        .rd_j_i    (j_q),
        .rd_data_o (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        size_i_d = size_i_q;
        size_j_d = size_j_q;
        data_d   = data_q;
        error_d  = 1'b0;
        wr_en    = 1'b0;
        strobe_i = 1'b0;
        strobe_j = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                wr_en = LOAD_ENABLE;
                if (START) begin
                    if (size_bad) begin
                        error_d = 1'b1;
                    end else begin
                        size_i_d = SIZE_I_IN;
                        size_j_d = SIZE_J_IN;
                        i_d      = C_ZERO;
                        j_d      = C_ZERO;
                        state_d  = ISSUE_I;
                    end
                end
            end
            ISSUE_I: begin
                strobe_i = 1'b1;
                strobe_j = 1'b1;
                data_d   = rd_data;
                state_d  = WAIT;
            end
            ISSUE_J: begin
                strobe_j = 1'b1;
                data_d   = rd_data;
                state_d  = WAIT;
            end
            WAIT: begin
                if (CONSUMER_READY) begin
                    state_d = DONE;
                end else if (NEXT_J_ENABLE && NEXT_I_ENABLE && (i_q < last_i)) begin
                    i_d     = i_q + C_ONE;
                    j_d     = C_ZERO;
                    state_d = ISSUE_I;
                end else if (NEXT_J_ENABLE && (j_q < last_j)) begin
                    j_d     = j_q + C_ONE;
                    state_d = ISSUE_J;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            i_q      <= C_ZERO;
            j_q      <= C_ZERO;
            size_i_q <= D_ZERO;
            size_j_q <= D_ZERO;
            data_q   <= D_ZERO;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            size_i_q <= size_i_d;
            size_j_q <= size_j_d;
            data_q   <= data_d;
            error_q  <= error_d;
        end
    end

    // The element is presented straight from the buffer while strobing and
    // held from data_q afterwards.
    assign DATA_OUT          = strobe_j ? rd_data : data_q;
    assign DATA_OUT_I_ENABLE = strobe_i;
    assign DATA_OUT_J_ENABLE = strobe_j;
    assign READY             = done | error_q;
    assign ERROR             = error_q;

endmodule

// File: doc/model_matrix_stream_source.md
MODEL_MATRIX_STREAM_SOURCE -- requirements
Module: model_matrix_stream_source

Interface
REQ-001 SHALL have a single clock CLK and an asynchronous, active-high reset RST.
REQ-002 Parameters SHALL be: DATA_SIZE, 64, element/size width; CONTROL_SIZE, 64, index width; MAX_I, 4, row capacity; MAX_J, 4, column capacity.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- CLK, in, 1, clock.
- RST, in, 1, async active-high reset.
- START, in, 1, begin streaming.
- READY, out, 1, one-cycle done pulse.
- ERROR, out, 1, one-cycle size-fault pulse.
- LOAD_ENABLE, in, 1, buffer write strobe.
- LOAD_I, in, CONTROL_SIZE, write row.
- LOAD_J, in, CONTROL_SIZE, write column.
- LOAD_DATA, in, DATA_SIZE, write value.
- SIZE_I_IN, in, DATA_SIZE, rows to stream.
- SIZE_J_IN, in, DATA_SIZE, columns to stream.
- DATA_OUT_I_ENABLE, out, 1, row-start element strobe.
- DATA_OUT_J_ENABLE, out, 1, element strobe.
- DATA_OUT, out, DATA_SIZE, element value.
- NEXT_I_ENABLE, in, 1, consumer requests next row.
- NEXT_J_ENABLE, in, 1, consumer requests next element.
- CONSUMER_READY, in, 1, consumer finished whole matrix.

Function
REQ-004 SHALL hold a MAX_I x MAX_J element buffer, written on LOAD_ENABLE in IDLE only; LOAD_I >= MAX_I or LOAD_J >= MAX_J is ignored.
REQ-005 FSM states SHALL be IDLE, ISSUE_I, ISSUE_J, WAIT, DONE; an unknown encoding SHALL go to IDLE.
REQ-006 In IDLE, START=1 SHALL latch sizes, clear i/j to 0 and go to ISSUE_I; START in any other state SHALL be ignored.
REQ-007 ISSUE_I SHALL drive DATA_OUT=buf[i][0] with DATA_OUT_I_ENABLE=DATA_OUT_J_ENABLE=1 for exactly one cycle, then go to WAIT; first strobe is 1 cycle after the START cycle.
REQ-008 ISSUE_J SHALL drive DATA_OUT=buf[i][j] with DATA_OUT_J_ENABLE=1 only for exactly one cycle, then go to WAIT.
REQ-009 In WAIT, precedence SHALL be: CONSUMER_READY -> DONE; else NEXT_J_ENABLE&NEXT_I_ENABLE with i<SIZE_I-1 -> i+1, j=0, ISSUE_I; else NEXT_J_ENABLE with j<SIZE_J-1 -> j+1, ISSUE_J; else remain in WAIT.
REQ-010 NEXT_* after the last element (i=SIZE_I-1, j=SIZE_J-1) without CONSUMER_READY SHALL be ignored.
REQ-011 DONE SHALL pulse READY for one cycle and return to IDLE.
REQ-012 DATA_OUT SHALL hold its last value when no strobe is active; strobes SHALL never exceed one cycle.
REQ-013 Index comparisons SHALL be unsigned at CONTROL_SIZE width.

Reset
REQ-014 RST=1 at any time, including mid-stream, SHALL force IDLE, READY=0, ERROR=0, both strobes=0, DATA_OUT=0, i=j=0; buffer contents are not reset.

Configuration
REQ-015 With MODEL_MATRIX_STREAM_SOURCE_SIZE_CHECK_EN defined, START with SIZE_I_IN=0, SIZE_J_IN=0, SIZE_I_IN>MAX_I or SIZE_J_IN>MAX_J SHALL pulse ERROR and READY together 1 cycle later, emit no strobe, and stay in IDLE.
REQ-016 Without the macro, ERROR SHALL be constant 0 and out-of-range sizes are caller error; behaviour in that case is not verified.

Structure
REQ-017 FSM state typedef and the ZERO/ONE control and data constants SHALL live in shared package model_matrix_pkg.
REQ-018 The buffer SHALL be a sub-module model_matrix_source_buffer with a synchronous write port and a combinational read port.

Verification
REQ-019 Load 2x2 {1,2,3,4}; START; consumer pulses NEXT_J, NEXT_J+NEXT_I, NEXT_J, then CONSUMER_READY -> strobes I+J:1, J:2, I+J:3, J:4, then READY one cycle.
REQ-020 Drive the stream into model_matrix_tanh_function 1x3 -> three J strobes (first also I), consumer READY observed, source READY follows.
REQ-021 RST asserted during WAIT after element (0,1) -> all outputs 0 immediately; subsequent START restreams from (0,0) with the unchanged buffer.
REQ-022 START during WAIT and LOAD_ENABLE during WAIT -> no effect on stream or buffer.
REQ-023 With SIZE_CHECK_EN, SIZE_I_IN=5 (MAX_I=4) -> ERROR=READY=1 for one cycle, no strobes; with SIZE_I_IN=0 -> same.
REQ-024 NEXT_J after the last element with CONSUMER_READY=0 for 10 cycles -> no strobe, state WAIT; then CONSUMER_READY=1 -> READY pulse.
